booth_product_serializer: RTL

//   Read-out end of the Booth product register: parallel-loads a WIDTH-bit product word
//   (load/D, same as the register write side) and streams it out serially, LSB first,

---
 rtl/booth_product_serializer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/booth_product_serializer.sv
// Parallel-load, LSB-first serializer for the Booth product register, with a valid/ready output.
// Optional trailing even-parity beat when BOOTH_SER_PARITY_EN is defined.
//
// Handshake: a beat transfers on a rising edge where ser_valid && ser_ready. While ser_valid
// is high and ser_ready is low, ser_out and ser_valid stay unchanged.
module booth_product_serializer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef BOOTH_SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
    } state_t;
`endif

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_ser_valid;
    logic               r_done;

    state_t             w_state_n;
    logic [WIDTH-1:0]   w_shreg_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic               w_busy_n;
    logic               w_ser_valid_n;
    logic               w_done_n;
    logic               w_accept;
    logic               w_last;

`ifdef BOOTH_SER_PARITY_EN
    logic               r_parity;
    logic               w_parity_n;
`endif

    assign w_accept = r_ser_valid && ser_ready;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
`ifdef BOOTH_SER_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_shreg     <= w_shreg_n;
            r_cnt       <= w_cnt_n;
            r_busy      <= w_busy_n;
            r_ser_valid <= w_ser_valid_n;
            r_done      <= w_done_n;
`ifdef BOOTH_SER_PARITY_EN
            r_parity    <= w_parity_n;
`endif
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_shreg_n     = r_shreg;
        w_cnt_n       = r_cnt;
        w_busy_n      = r_busy;
        w_ser_valid_n = r_ser_valid;
        w_done_n      = 1'b0;
`ifdef BOOTH_SER_PARITY_EN
        w_parity_n    = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_busy_n      = 1'b0;
                w_ser_valid_n = 1'b0;
                if (load) begin
                    w_state_n     = ST_SEND;
                    w_shreg_n     = D;
                    w_cnt_n       = '0;
                    w_busy_n      = 1'b1;
                    w_ser_valid_n = 1'b1;
`ifdef BOOTH_SER_PARITY_EN
                    w_parity_n    = ^D;
`endif
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    // After the last data shift the register is all zeros, so ser_out idles low.
                    w_shreg_n = r_shreg >> 1;
                    w_cnt_n   = r_cnt + 1'b1;
                    if (w_last) begin
`ifdef BOOTH_SER_PARITY_EN
                        w_state_n = ST_PARITY;
                        w_shreg_n = WIDTH'(r_parity);
`else
                        w_state_n     = ST_IDLE;
                        w_busy_n      = 1'b0;
                        w_ser_valid_n = 1'b0;
                        w_done_n      = 1'b1;
`endif
                    end
                end
            end
`ifdef BOOTH_SER_PARITY_EN
            ST_PARITY: begin
                if (w_accept) begin
                    w_state_n     = ST_IDLE;
                    w_shreg_n     = '0;
                    w_busy_n      = 1'b0;
                    w_ser_valid_n = 1'b0;
                    w_done_n      = 1'b1;
                end
            end
`endif
            default: begin
                w_state_n     = ST_IDLE;
                w_busy_n      = 1'b0;
                w_ser_valid_n = 1'b0;
            end
        endcase
    end

    assign busy      = r_busy;
    assign ser_out   = r_shreg[0];
    assign ser_valid = r_ser_valid;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
